// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared types and constants for the machine-mode trap sequencer
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SAVE,
    ST_VECTOR,
    ST_RET
  } state_e;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] CAUSE_LD_MIS  = 4'd4;
  localparam logic [3:0] CAUSE_ST_MIS  = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;
  localparam logic [3:0] CAUSE_MEI     = 4'd11;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef struct packed {
    logic       valid;
    logic       intr;
    logic [3:0] code;
    logic       is_ret;
  } trap_evt_t;

endpackage

// File: rtl/trap_sequencer_if.sv
// rtl/trap_sequencer_if.sv - exception/CSR/PC-mux signal bundle around the trap sequencer
interface trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            exc_addr_misalign;
  logic            exc_is_store;
  logic            exc_ecall;
  logic            exc_ebreak;
  logic            exc_illegal;
  logic            is_mret;
  logic            irq_ext;
  logic            irq_timer;
  logic            mstatus_mie;
  logic            mie_meie;
  logic            mie_mtie;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            mepc_we;
  logic [XLEN-1:0] mepc_wdata;
  logic            mcause_we;
  logic [XLEN-1:0] mcause_val;
  logic            mstatus_trap;
  logic            mstatus_ret;
  logic            flush;
  logic            stall;
  logic            pc_redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  modport master (
    input  exc_addr_misalign, exc_is_store, exc_ecall, exc_ebreak, exc_illegal,
    input  is_mret, irq_ext, irq_timer, mstatus_mie, mie_meie, mie_mtie,
    input  ex_pc, mtvec, mepc,
    output mepc_we, mepc_wdata, mcause_we, mcause_val, mstatus_trap, mstatus_ret,
    output flush, stall, pc_redirect, redirect_pc, busy
  );

  modport slave (
    output exc_addr_misalign, exc_is_store, exc_ecall, exc_ebreak, exc_illegal,
    output is_mret, irq_ext, irq_timer, mstatus_mie, mie_meie, mie_mtie,
    output ex_pc, mtvec, mepc,
    input  mepc_we, mepc_wdata, mcause_we, mcause_val, mstatus_trap, mstatus_ret,
    input  flush, stall, pc_redirect, redirect_pc, busy
  );
endinterface

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - picks the single highest-priority trap or mret event this cycle
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic      exc_addr_misalign_i,
  input  logic      exc_is_store_i,
  input  logic      exc_ecall_i,
  input  logic      exc_ebreak_i,
  input  logic      exc_illegal_i,
  input  logic      is_mret_i,
  input  logic      irq_ext_i,
  input  logic      irq_timer_i,
  input  logic      mstatus_mie_i,
  input  logic      mie_meie_i,
  input  logic      mie_mtie_i,
  output trap_evt_t evt_o
);

  logic ext_ok;
  logic tmr_ok;

  assign ext_ok = irq_ext_i & mstatus_mie_i & mie_meie_i;
  assign tmr_ok = irq_timer_i & mstatus_mie_i & mie_mtie_i;

  // Synchronous exceptions always outrank mret and interrupts.
  always_comb begin
    evt_o = '0;
    if (exc_illegal_i) begin
      evt_o = '{valid: 1'b1, intr: 1'b0, code: CAUSE_ILLEGAL, is_ret: 1'b0};
    end else if (exc_ebreak_i) begin
      evt_o = '{valid: 1'b1, intr: 1'b0, code: CAUSE_BREAK, is_ret: 1'b0};
    end else if (exc_ecall_i) begin
      evt_o = '{valid: 1'b1, intr: 1'b0, code: CAUSE_ECALL_M, is_ret: 1'b0};
    end else if (exc_addr_misalign_i) begin
      evt_o = '{valid: 1'b1, intr: 1'b0,
                code: exc_is_store_i ? CAUSE_ST_MIS : CAUSE_LD_MIS, is_ret: 1'b0};
    end else if (is_mret_i) begin
      evt_o = '{valid: 1'b1, intr: 1'b0, code: 4'd0, is_ret: 1'b1};
    end else if (ext_ok) begin
      evt_o = '{valid: 1'b1, intr: 1'b1, code: CAUSE_MEI, is_ret: 1'b0};
    end else if (tmr_ok) begin
      evt_o = '{valid: 1'b1, intr: 1'b1, code: CAUSE_MTI, is_ret: 1'b0};
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - sequences trap entry (flush, CSR save, vector) and mret return
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit VECTORED_EN = 1'b1,
  parameter int RET_LAT     = 1
) (
  input  logic             clk,
  input  logic             rst,
  trap_sequencer_if.master bus
);

  trap_evt_t       evt;
  state_e          state_q;
  logic [1:0]      ret_cnt_q;
  logic            busy_q, flush_q, stall_q;
  logic            mepc_we_q, mcause_we_q, trap_q, ret_q, redirect_q;
  logic [XLEN-1:0] mcause_val_q, epc_q, redirect_pc_q;
  logic [XLEN-1:0] vector_pc_d;

  trap_prio_enc u_prio (
    .exc_addr_misalign_i (bus.exc_addr_misalign),
    .exc_is_store_i      (bus.exc_is_store),
    .exc_ecall_i         (bus.exc_ecall),
    .exc_ebreak_i        (bus.exc_ebreak),
    .exc_illegal_i       (bus.exc_illegal),
    .is_mret_i           (bus.is_mret),
    .irq_ext_i           (bus.irq_ext),
    .irq_timer_i         (bus.irq_timer),
    .mstatus_mie_i       (bus.mstatus_mie),
    .mie_meie_i          (bus.mie_meie),
    .mie_mtie_i          (bus.mie_mtie),
    .evt_o               (evt)
  );

  // Vectored mode only applies to interrupts; exceptions always use the base.
  always_comb begin
    vector_pc_d = {bus.mtvec[XLEN-1:2], 2'b00};
    if (VECTORED_EN && bus.mtvec[1:0] == MTVEC_VECTORED && mcause_val_q[XLEN-1]) begin
      vector_pc_d = vector_pc_d + XLEN'({mcause_val_q[3:0], 2'b00});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ret_cnt_q     <= '0;
      busy_q        <= 1'b0;
      flush_q       <= 1'b0;
      stall_q       <= 1'b0;
      mepc_we_q     <= 1'b0;
      mcause_we_q   <= 1'b0;
      trap_q        <= 1'b0;
      ret_q         <= 1'b0;
      redirect_q    <= 1'b0;
      mcause_val_q  <= '0;
      epc_q         <= '0;
      redirect_pc_q <= '0;
    end else begin
      flush_q     <= 1'b0;
      stall_q     <= 1'b0;
      mepc_we_q   <= 1'b0;
      mcause_we_q <= 1'b0;
      trap_q      <= 1'b0;
      ret_q       <= 1'b0;
      redirect_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (evt.valid) begin
            busy_q  <= 1'b1;
            flush_q <= 1'b1;
            stall_q <= 1'b1;
            if (evt.is_ret) begin
              state_q       <= ST_RET;
              ret_q         <= 1'b1;
              ret_cnt_q     <= 2'(RET_LAT - 1);
              redirect_q    <= (RET_LAT == 1);
              redirect_pc_q <= bus.mepc;
            end else begin
              state_q      <= ST_FLUSH;
              mcause_val_q <= {evt.intr, {(XLEN-5){1'b0}}, evt.code};
              epc_q        <= {bus.ex_pc[XLEN-1:2], 2'b00};
            end
          end
        end
        ST_FLUSH: begin
          state_q     <= ST_SAVE;
          stall_q     <= 1'b1;
          mepc_we_q   <= 1'b1;
          mcause_we_q <= 1'b1;
          trap_q      <= 1'b1;
        end
        ST_SAVE: begin
          state_q       <= ST_VECTOR;
          flush_q       <= 1'b1;
          redirect_q    <= 1'b1;
          redirect_pc_q <= vector_pc_d;
        end
        ST_VECTOR: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_RET: begin
          if (ret_cnt_q == 2'd0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            ret_cnt_q     <= ret_cnt_q - 2'd1;
            flush_q       <= 1'b1;
            stall_q       <= 1'b1;
            redirect_q    <= (ret_cnt_q == 2'd1);
            redirect_pc_q <= bus.mepc;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.flush        = flush_q;
  assign bus.stall        = stall_q;
  assign bus.mepc_we      = mepc_we_q;
  assign bus.mepc_wdata   = epc_q;
  assign bus.mcause_we    = mcause_we_q;
  assign bus.mcause_val   = mcause_val_q;
  assign bus.mstatus_trap = trap_q;
  assign bus.mstatus_ret  = ret_q;
  assign bus.pc_redirect  = redirect_q;
  assign bus.redirect_pc  = redirect_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - scoreboard bench for trap_sequencer
module tb_trap_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(32)) bus ();

  trap_sequencer #(.XLEN(32), .VECTORED_EN(1'b1), .RET_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]  flags;
    logic [31:0] rpc;
    logic [31:0] cause;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  // flags: busy, flush, stall, mepc_we, mcause_we, mstatus_trap, mstatus_ret, pc_redirect
  function automatic logic [7:0] act_flags();
    return {bus.busy, bus.flush, bus.stall, bus.mepc_we, bus.mcause_we,
            bus.mstatus_trap, bus.mstatus_ret, bus.pc_redirect};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] f, input logic [31:0] rpc,
                      input logic [31:0] cause, input logic [31:0] wdata);
    exp_t e;
    e.flags = f; e.rpc = rpc; e.cause = cause; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  task automatic push_trap(input logic [31:0] cause, input logic [31:0] wdata,
                           input logic [31:0] rpc);
    push(8'b1110_0000, 32'h0, cause, wdata);
    push(8'b1011_1100, 32'h0, cause, wdata);
    push(8'b1100_0001, rpc, cause, wdata);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bus.busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_busy: flags=%b with empty queue at %0t", act_flags(), $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("flags", {24'h0, act_flags()}, {24'h0, e.flags});
          check("mcause_val", bus.mcause_val, e.cause);
          if (e.flags[0]) check("redirect_pc", bus.redirect_pc, e.rpc);
          if (e.flags[4]) check("mepc_wdata", bus.mepc_wdata, e.wdata);
        end
      end else begin
        check("idle_flags", {24'h0, act_flags()}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.exc_addr_misalign = 0; bus.exc_is_store = 0; bus.exc_ecall = 0;
    bus.exc_ebreak = 0; bus.exc_illegal = 0; bus.is_mret = 0;
    bus.irq_ext = 0; bus.irq_timer = 0; bus.mstatus_mie = 0;
    bus.mie_meie = 0; bus.mie_mtie = 0;
    bus.ex_pc = 32'h0; bus.mtvec = 32'h0; bus.mepc = 32'h0;
    step(3);
    check("reset_flags", {24'h0, act_flags()}, 32'h0);
    check("reset_mcause", bus.mcause_val, 32'h0);
    rst = 1'b0;
    step(2);

    // illegal instruction, direct vector
    bus.exc_illegal = 1; bus.ex_pc = 32'h0000_0104; bus.mtvec = 32'h0000_0200;
    push_trap(32'h2, 32'h104, 32'h200);
    step(1);
    bus.exc_illegal = 0;
    step(3);
    check("t1_busy_after", {31'h0, bus.busy}, 32'h0);
    step(2);

    // ecall outranks store misalign
    bus.exc_addr_misalign = 1; bus.exc_is_store = 1; bus.exc_ecall = 1;
    bus.ex_pc = 32'h0000_0204;
    push_trap(32'hB, 32'h204, 32'h200);
    step(1);
    bus.exc_addr_misalign = 0; bus.exc_is_store = 0; bus.exc_ecall = 0;
    step(5);

    // store misalign alone, unaligned ex_pc truncated
    bus.exc_addr_misalign = 1; bus.exc_is_store = 1; bus.ex_pc = 32'h0000_010A;
    push_trap(32'h6, 32'h108, 32'h200);
    step(1);
    bus.exc_addr_misalign = 0; bus.exc_is_store = 0;
    step(5);

    // timer interrupt, vectored mtvec
    bus.irq_timer = 1; bus.mstatus_mie = 1; bus.mie_mtie = 1; bus.mtvec = 32'h0000_0301;
    push_trap(32'h8000_0007, 32'h108, 32'h31C);
    step(1);
    bus.irq_timer = 0;
    step(5);

    // timer interrupt masked globally
    bus.mstatus_mie = 0; bus.irq_timer = 1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("masked_busy", {31'h0, bus.busy}, 32'h0);
    end
    bus.irq_timer = 0; bus.mie_mtie = 0;
    step(2);

    // mret with single-cycle return
    bus.is_mret = 1; bus.mepc = 32'h0000_0408;
    push(8'b1110_0011, 32'h408, 32'h8000_0007, 32'h0);
    step(1);
    bus.is_mret = 0;
    step(1);
    check("mret_busy_after", {31'h0, bus.busy}, 32'h0);
    step(2);

    // exception wins over simultaneous enabled external interrupt
    bus.mstatus_mie = 1; bus.mie_meie = 1; bus.irq_ext = 1;
    bus.exc_illegal = 1; bus.ex_pc = 32'h0000_0500;
    push_trap(32'h2, 32'h500, 32'h300);
    push_trap(32'h8000_000B, 32'h500, 32'h32C);
    step(1);
    bus.exc_illegal = 0;
    step(3);
    check("between_traps_busy", {31'h0, bus.busy}, 32'h0);
    step(1);
    bus.irq_ext = 0;
    step(3);
    check("irq_done_busy", {31'h0, bus.busy}, 32'h0);
    bus.mstatus_mie = 0; bus.mie_meie = 0;
    step(2);

    // reset during SAVE aborts the sequence
    bus.exc_illegal = 1; bus.ex_pc = 32'h0000_0600; bus.mtvec = 32'h0000_0200;
    push(8'b1110_0000, 32'h0, 32'h2, 32'h600);
    push(8'b1011_1100, 32'h0, 32'h2, 32'h600);
    step(1);
    bus.exc_illegal = 0;
    step(1);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_flags", {24'h0, act_flags()}, 32'h0);
    check("abort_mcause", bus.mcause_val, 32'h0);
    check("abort_redirect_pc", bus.redirect_pc, 32'h0);
    step(4);
    check("abort_busy_later", {31'h0, bus.busy}, 32'h0);

    check("queue_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
Multi-cycle controller that sequences machine-mode trap entry and mret return for the RV32I pipeline. It collects exception flags from the decode/exception-detect logic and interrupt requests from the platform, and selects one event. It then drives the CSR unit write strobes (mepc, mcause, mstatus) and the pipeline flush/stall/redirect controls in a fixed order. It sits between the ID-stage exception detection, the CSR unit and the IF-stage PC mux.

Parameters:
XLEN, 32, datapath/CSR width
VECTORED_EN, 1, 1 = honour mtvec[1:0]==01 vectored mode for interrupts; 0 = always direct mode
RET_LAT, 1, extra cycles held in RET before redirect (1..3)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
exc_addr_misalign  in  1  load/store address misaligned
exc_is_store  in  1  qualifies misalign: 1 = store, 0 = load
exc_ecall  in  1  ecall decoded
exc_ebreak  in  1  ebreak decoded
exc_illegal  in  1  illegal instruction
is_mret  in  1  mret decoded
irq_ext  in  1  external interrupt request (level)
irq_timer  in  1  timer interrupt request (level)
mstatus_mie  in  1  global interrupt enable from CSR unit
mie_meie  in  1  external interrupt enable
mie_mtie  in  1  timer interrupt enable
ex_pc  in  XLEN  PC of the instruction in EX
mtvec  in  XLEN  trap vector CSR
mepc  in  XLEN  saved exception PC CSR
mepc_we  out  1  write ex_pc[31:2],2'b00 to mepc
mcause_we  out  1  write mcause_val to mcause
mcause_val  out  XLEN  {intr_bit, 27'b0, code[3:0]}
mstatus_trap  out  1  CSR unit: mpie<=mie, mie<=0
mstatus_ret  out  1  CSR unit: mie<=mpie, mpie<=1
flush  out  1  squash IF/ID/EX
stall  out  1  freeze PC and pipeline registers
pc_redirect  out  1  load redirect_pc into PC
redirect_pc  out  XLEN  trap target or mepc
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; all outputs 0; latched cause cleared. rst mid-sequence aborts without completing CSR writes.
- States: IDLE, FLUSH, SAVE, VECTOR, RET.
- Event priority in IDLE, evaluated per cycle: exc_illegal (code 2) > exc_ebreak (3) > exc_ecall (11) > misalign (store 6 / load 4) > is_mret > ext irq (intr=1, code 11) > timer irq (intr=1, code 7).
- Interrupts are eligible only when mstatus_mie & matching enable; otherwise ignored.
- Exception/interrupt: IDLE->FLUSH (flush=1, stall=1; cause and ex_pc latched at this edge) -> SAVE (mepc_we=1, mcause_we=1, mstatus_trap=1, stall=1, each a 1-cycle pulse) -> VECTOR (pc_redirect=1, flush=1) -> IDLE. Redirect occurs on the third cycle after the event is sampled.
- redirect_pc in VECTOR: {mtvec[31:2],2'b00}. If VECTORED_EN, mtvec[1:0]==01 and the latched event is an interrupt, the value is base + 4*code.
- mret: IDLE->RET (flush=1, stall=1, mstatus_ret=1 pulse on the first RET cycle). Hold RET for RET_LAT cycles; the last cycle asserts pc_redirect=1 with redirect_pc=mepc. Then IDLE.
- All inputs are ignored outside IDLE, because the pipeline is stalled. Interrupts are level-sensitive and are re-evaluated on return to IDLE.
- Simultaneous exception and interrupt: the exception wins and the interrupt stays pending.
- Simultaneous mret and exception: the exception wins.
- busy=1 in every non-IDLE state. Strobes never overlap across states.
- mcause_val holds the latched value from FLUSH until the next event.

Decomposition:
- Shared package trap_pkg:
  - state enum.
  - cause code constants CAUSE_ILLEGAL=2, CAUSE_BREAK=3, CAUSE_LD_MIS=4, CAUSE_ST_MIS=6, CAUSE_ECALL_M=11, CAUSE_MTI=7, CAUSE_MEI=11.
  - MTVEC_VECTORED=2'b01.
- Sub-module trap_prio_enc: combinational priority encoder producing {valid, intr_bit, code, is_ret}.
- FSM and output register logic stay in trap_sequencer.

Test Plan:
- exc_illegal=1, ex_pc=0x0000_0104, mtvec=0x0000_0200 -> cycle1 flush; cycle2 mepc_we, mcause_we, mcause_val=0x2, mstatus_trap; cycle3 pc_redirect, redirect_pc=0x200; busy=0 at cycle4.
- exc_addr_misalign=1, exc_is_store=1 with exc_ecall=1 in the same cycle -> mcause_val=0xB (ecall outranks misalign). Repeat with ecall=0 -> 0x6.
- irq_timer=1, mstatus_mie=1, mie_mtie=1, mtvec=0x0000_0301, VECTORED_EN=1 -> mcause_val=0x8000_0007, redirect_pc=0x31C. Repeat with mstatus_mie=0 -> no activity, busy stays 0.
- is_mret=1, mepc=0x0000_0408, RET_LAT=1 -> flush, mstatus_ret and pc_redirect all asserted in the same cycle with redirect_pc=0x408.
- irq_ext=1 enabled while exc_illegal=1 -> illegal trap completes first (mcause=0x2). The interrupt trap (0x8000_000B) starts on the cycle after return to IDLE.
- rst=1 asserted during SAVE -> the next cycle has state IDLE and all outputs 0, with no pc_redirect ever asserted.
